// File: rtl/comb_bist_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : comb_bist_ctrl_if
// Description : Control/observation bundle between a BIST controller and
//               whoever drives it. The controller attaches through the slave
//               modport; the test harness or host attaches through master.
// Signals     : start, abort   - run control (master -> slave)
//               exp_sig        - golden signature (master -> slave)
//               resp_in        - responses of the logic under test
//               pat_out        - stimulus for the logic under test
//               pat_idx        - index of the pattern currently applied
//               signature      - MISR contents
//               busy/done/pass - run status
// Revision    : 1.0 - initial release
// ============================================================================
interface comb_bist_ctrl_if #(
   parameter int IN_W         = 4,
   parameter int OUT_W        = 3,
   parameter int SIG_W        = 8,
   parameter int NUM_PATTERNS = 16
);
   localparam int IDX_W = $clog2(NUM_PATTERNS + 1);

   logic             start;
   logic             abort;
   logic [SIG_W-1:0] exp_sig;
   logic [OUT_W-1:0] resp_in;
   logic [IN_W-1:0]  pat_out;
   logic [IDX_W-1:0] pat_idx;
   logic [SIG_W-1:0] signature;
   logic             busy;
   logic             done;
   logic             pass;

   modport master (
      output start, abort, exp_sig, resp_in,
      input  pat_out, pat_idx, signature, busy, done, pass
   );

   modport slave (
      input  start, abort, exp_sig, resp_in,
      output pat_out, pat_idx, signature, busy, done, pass
   );
endinterface
`default_nettype wire

// File: rtl/comb_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : comb_bist_ctrl
// Description : Built-in self-test controller for combinational netlists.
//               A Galois LFSR supplies patterns, each held for SETTLE+1
//               cycles; the response is folded into a Galois MISR on the
//               last cycle of each pattern. After NUM_PATTERNS captures the
//               signature is compared against exp_sig.
// Ports       : clk  - clock, rising edge
//               rst  - asynchronous active-high reset
//               bus  - comb_bist_ctrl_if.slave (start, abort, exp_sig,
//                      resp_in in; pat_out, pat_idx, signature, busy,
//                      done, pass out)
// Revision    : 1.0 - initial release
// ============================================================================
module comb_bist_ctrl #(
   parameter int               IN_W         = 4,
   parameter int               OUT_W        = 3,
   parameter int               SIG_W        = 8,
   parameter int               NUM_PATTERNS = 16,
   parameter int               SETTLE       = 1,
   parameter logic [IN_W-1:0]  LFSR_SEED    = IN_W'(1),
   parameter logic [IN_W-1:0]  LFSR_TAPS    = 4'b1100,
   parameter logic [SIG_W-1:0] MISR_TAPS    = 8'hB8
) (
   input  wire logic       clk,
   input  wire logic       rst,
   comb_bist_ctrl_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_PATTERNS + 1);
   localparam int CNT_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

   // An all-zero seed would lock the LFSR, so it is replaced by 1.
   localparam logic [IN_W-1:0]  SEED     = (LFSR_SEED == '0) ? IN_W'(1) : LFSR_SEED;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PATTERNS - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      APPLY = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [IN_W-1:0]  r_lfsr;
   logic [SIG_W-1:0] r_sig;
   logic [CNT_W-1:0] r_cnt;
   logic [IDX_W-1:0] r_idx;
   logic             r_done;
   logic             r_pass;

   logic             w_start_run;
   logic             w_capture;
   logic             w_final;
   logic [SIG_W-1:0] w_sig_next;
   logic [IN_W-1:0]  w_lfsr_next;

   // Next-state and capture decode
   always_comb begin
      w_state_next = r_state;
      w_start_run  = 1'b0;
      w_capture    = 1'b0;
      w_final      = 1'b0;
      w_sig_next   = (r_sig >> 1) ^ (r_sig[0] ? MISR_TAPS : '0) ^ SIG_W'(bus.resp_in);
      w_lfsr_next  = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : '0);

      case (r_state)
         IDLE, DONE: begin
            if (bus.start) begin
               w_start_run  = 1'b1;
               w_state_next = APPLY;
            end
         end
         APPLY: begin
            // abort wins over a capture landing on the same edge
            if (bus.abort) begin
               w_state_next = IDLE;
            end else if (r_cnt == CNT_LAST) begin
               w_capture = 1'b1;
               if (r_idx == LAST_IDX) begin
                  w_final      = 1'b1;
                  w_state_next = DONE;
               end
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_lfsr  <= '0;
         r_sig   <= '0;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_done  <= 1'b0;
         r_pass  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (w_start_run) begin
            r_lfsr <= SEED;
            r_sig  <= '0;
            r_cnt  <= '0;
            r_idx  <= '0;
            r_done <= 1'b0;
            r_pass <= 1'b0;
         end else if (r_state == APPLY) begin
            if (bus.abort) begin
               // signature is deliberately kept for post-mortem inspection
               r_idx  <= '0;
               r_cnt  <= '0;
               r_done <= 1'b0;
               r_pass <= 1'b0;
            end else if (w_capture) begin
               r_sig  <= w_sig_next;
               r_lfsr <= w_lfsr_next;
               r_idx  <= r_idx + 1'b1;
               r_cnt  <= '0;
               if (w_final) begin
                  r_done <= 1'b1;
                  r_pass <= (w_sig_next == bus.exp_sig);
               end
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

   assign bus.busy      = (r_state == APPLY);
   assign bus.pat_out   = (r_state == APPLY) ? r_lfsr : '0;
   assign bus.pat_idx   = r_idx;
   assign bus.signature = r_sig;
   assign bus.done      = r_done;
   assign bus.pass      = r_pass;
endmodule
`default_nettype wire

// File: doc/comb_bist_ctrl.md
# comb_bist_ctrl

Parametrised built-in self-test controller for combinational gate-level netlists (or2/and2/nand2/not1 networks, including ones with feedback loops). Generates pseudo-random input patterns from a Galois LFSR, waits a programmable settle time per pattern, and compacts DUT responses into a MISR signature. Replaces free-running toggle-register stimulus and `$monitor` inspection with a single pass/fail result and a signature that can be checked against a golden value.

## Interface

Parameters:
- IN_W, 4, DUT input width; LFSR width.
- OUT_W, 3, DUT output width; must be ≤ SIG_W.
- SIG_W, 8, MISR width.
- NUM_PATTERNS, 16, patterns applied per run; ≥ 1.
- SETTLE, 1, cycles each pattern is held before capture; ≥ 1.
- LFSR_SEED, 1, initial LFSR state; a zero value is replaced by 1.
- LFSR_TAPS, 4'b1100, Galois feedback mask (x^4+x^3+1).
- MISR_TAPS, 8'hB8, Galois feedback mask for MISR.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin run; sampled in IDLE and DONE only.
- abort  input  1  abandon run; return to IDLE.
- exp_sig  input  SIG_W  golden signature.
- resp_in  input  OUT_W  DUT outputs.
- pat_out  output  IN_W  DUT inputs.
- pat_idx  output  clog2(NUM_PATTERNS+1)  index of current pattern.
- signature  output  SIG_W  MISR contents.
- busy  output  1  run in progress.
- done  output  1  run completed.
- pass  output  1  done and signature == exp_sig.

## Operation

- States: IDLE, APPLY, DONE.
- Reset (async): state IDLE; pat_out=0, pat_idx=0, signature=0, busy=0, done=0, pass=0, settle counter=0.
- IDLE/DONE: pat_out=0. In DONE, signature, done and pass hold their values.
- start=1 in IDLE or DONE → APPLY. Load LFSR = seed (nonzero), clear signature, pat_idx=0, done=0, pass=0, busy=1.
- APPLY: pat_out = LFSR state. The settle counter counts SETTLE+1 cycles. On the last cycle (the capture edge):
  - MISR: sig ← (sig>>1) ^ (sig[0] ? MISR_TAPS : 0) ^ zero-extend(resp_in).
  - LFSR: s ← (s>>1) ^ (s[0] ? LFSR_TAPS : 0).
  - pat_idx increments.
  - If this is capture number NUM_PATTERNS → DONE: busy=0, done=1, pass=(new signature == exp_sig).
- start while busy is ignored.
- abort=1 in APPLY → IDLE. Clears busy, done, pass and pat_idx. signature is left unchanged. abort has priority over capture in the same cycle. abort in IDLE/DONE has no effect.
- exp_sig is sampled only on the final capture edge.
- LFSR wraps after 2^IN_W−1 states with maximal taps. NUM_PATTERNS greater than the period simply repeats patterns.

## Timing

- start sampled at edge E0. busy=1 and pat_out=seed are visible after E0.
- Captures occur at edges E0 + k·(SETTLE+1), for k=1..NUM_PATTERNS. resp_in is sampled at each capture edge, so the DUT has SETTLE+1 full cycles to settle.
- done/pass become visible after edge E0 + NUM_PATTERNS·(SETTLE+1). busy drops on the same edge.
- Restart from DONE: start at edge E' begins the new run with identical timing. done falls after E'.
- rst asserted mid-run: all outputs go to reset values immediately, without waiting for clk.

## Test plan

- Reset mid-run: rst pulsed asynchronously at pattern 2 → all outputs 0 immediately. Next start runs normally.
- LFSR sequence: defaults, resp_in=0, NUM_PATTERNS=15 → pat_out per pattern = 1,C,6,3,D,A,5,E,7,F,B,9,8,4,2. Final signature=00. pass=1 with exp_sig=00.
- MISR: resp_in tied to 3'b001, NUM_PATTERNS=4, SETTLE=1 → signature after each capture = 01, B9, E5, CB. done after E0+8. pass=1 with exp_sig=CB, pass=0 with exp_sig=CA.
- Settle and latency: SETTLE=3, NUM_PATTERNS=2 → each pat_out held 4 cycles. done rises after E0+8.
- Abort and start-while-busy: start pulsed during APPLY → run unaffected. abort at the same edge as the 3rd capture → IDLE with busy=0, done=0, pat_idx=0.
- Loop DUT: gate network with a combinational feedback loop, wired as the DUT with SETTLE=2 → signature matches the value from a reference model. Rerunning from DONE reproduces an identical signature.
